// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// The optional same-cycle bypass is enabled by defining IFQ_BYPASS_EN.
package if_id_queue_pkg;

    localparam int          IFQ_DEPTH = 4;
    localparam int          IFQ_PTR_W = 2;
    localparam int          REG_W     = 32;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic        RST_ENABLE = 1'b0;

    // One queued fetch word; 4 x 32 + 1 = 129 bits.
    typedef struct packed {
        logic [REG_W-1:0] pc;
        logic [31:0]      inst;
        logic [REG_W-1:0] next_pc;
        logic             next_branch;
        logic [31:0]      exception;
    } ifq_entry_t;

    localparam int ENTRY_W = $bits(ifq_entry_t);

    // What the decoder sees when nothing is queued: a bubble identical to a flushed IF/ID.
    localparam ifq_entry_t EMPTY_ENTRY = '{
        pc:          ZERO_WORD,
        inst:        NOP_INST,
        next_pc:     ZERO_WORD,
        next_branch: 1'b0,
        exception:   ZERO_WORD
    };

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side signals of the instruction queue.
// Handshake: a fetch word transfers on a clock edge where fetch_valid_i and
// fetch_ready_o are both high; the head entry is consumed on an edge where
// valid_o is high, the IF/ID stall bit is clear and no flush is active.
interface if_id_queue_if;
    import if_id_queue_pkg::*;

    logic             fetch_valid_i;
    logic             fetch_ready_o;
    logic [REG_W-1:0] fetch_pc_i;
    logic [31:0]      fetch_inst_i;
    logic [REG_W-1:0] fetch_next_pc_i;
    logic             fetch_next_branch_i;
    logic [31:0]      fetch_exception_i;

    logic             valid_o;
    logic [REG_W-1:0] pc_o;
    logic [31:0]      inst_o;
    logic [REG_W-1:0] next_pc_o;
    logic             next_branch_o;
    logic [31:0]      exception_o;

    // Queue's view.
    modport slave (
        input  fetch_valid_i, fetch_pc_i, fetch_inst_i, fetch_next_pc_i,
               fetch_next_branch_i, fetch_exception_i,
        output fetch_ready_o, valid_o, pc_o, inst_o, next_pc_o,
               next_branch_o, exception_o
    );

    // Fetch/decode side's view.
    modport master (
        output fetch_valid_i, fetch_pc_i, fetch_inst_i, fetch_next_pc_i,
               fetch_next_branch_i, fetch_exception_i,
        input  fetch_ready_o, valid_o, pc_o, inst_o, next_pc_o,
               next_branch_o, exception_o
    );

endinterface

// File: rtl/if_id_queue_mem.sv
// ifq_mem: DEPTH x 129-bit entry storage, one write port, one async read port.
// Contents are deliberately not reset; validity is tracked by the queue count.
module ifq_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  ifq_entry_t       wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output ifq_entry_t       rdata_o
);

    ifq_entry_t mem_q [DEPTH];

    // Write the accepted fetch word into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction queue replacing the IF/ID register.
// Fetch runs ahead of decode; the head entry is presented combinationally.
// Define IFQ_BYPASS_EN to let a fetch word reach decode in the same cycle
// when the queue is empty; otherwise the path is fully registered.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic [5:0]       stall_i,
    input  logic             flush_i,
    if_id_queue_if.slave     ifq,
    output logic [PTR_W:0]   dbg_count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic       fetch_ready;
    logic       stop;
    logic       bypass;
    logic       head_valid;
    logic       enq;
    logic       deq;
    logic       wr_en;
    logic       rd_adv;
    ifq_entry_t fetch_entry;
    ifq_entry_t rd_entry;
    ifq_entry_t head_entry;

    // Only the IF/ID bit of the shared stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

    // Pack the fetch-side fields into one entry.
    always_comb begin
        fetch_entry             = EMPTY_ENTRY;
        fetch_entry.pc          = ifq.fetch_pc_i;
        fetch_entry.inst        = ifq.fetch_inst_i;
        fetch_entry.next_pc     = ifq.fetch_next_pc_i;
        fetch_entry.next_branch = ifq.fetch_next_branch_i;
        fetch_entry.exception   = ifq.fetch_exception_i;
    end

    ifq_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (fetch_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Handshake decode and next pointer/count; flush overrides everything.
    always_comb begin
        // Ready looks only at the registered count: no pass-through when full.
        fetch_ready = (count_q != FULL_CNT) && !flush_i;
        stop        = (stall_i[1] == STOP);
        bypass      = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass      = (count_q == '0) && ifq.fetch_valid_i && !flush_i;
`endif
        head_valid  = (count_q != '0) || bypass;
        deq         = head_valid && !stop && !flush_i;
        enq         = ifq.fetch_valid_i && fetch_ready;
        // A bypassed word consumed this cycle never lands in storage.
        wr_en       = enq && !(bypass && deq);
        rd_adv      = deq && (count_q != '0);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset discards every entry at once.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (n_rst_i == RST_ENABLE) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Select what the decoder sees: bypassed word, stored head, or a bubble.
    always_comb begin
        head_entry = EMPTY_ENTRY;
        if (bypass) begin
            head_entry = fetch_entry;
        end else if (count_q != '0) begin
            head_entry = rd_entry;
        end
    end

    assign ifq.fetch_ready_o = fetch_ready;
    assign ifq.valid_o       = head_valid;
    assign ifq.pc_o          = head_entry.pc;
    assign ifq.inst_o        = head_entry.inst;
    assign ifq.next_pc_o     = head_entry.next_pc;
    assign ifq.next_branch_o = head_entry.next_branch;
    assign ifq.exception_o   = head_entry.exception;
    assign dbg_count_o       = count_q;

endmodule
